// File: rtl/debouncer_pkg.sv
// Shared types and helpers for the per-bit debouncer.
package debouncer_pkg;

  // Per-bit qualification state: idle on the accepted level, or counting a candidate change.
  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } deb_state_t;

  localparam int DEB_STABLE_CYCLES_DEF = 16;

  // Counter width for a qualification window of `cycles` samples.
  // The counter only ever holds 0..cycles-1.
  function automatic int deb_cnt_w(int cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// Single-bit debounce FSM: qualifies a level change over STABLE_CYCLES samples,
// then emits a one-cycle rise/fall pulse.
// Optional sticky abort flag is enabled with DEBOUNCER_GLITCH_FLAG_EN.
module debounce_cell
  import debouncer_pkg::*;
#(
  parameter int   STABLE_CYCLES = DEB_STABLE_CYCLES_DEF,
  parameter logic RESET_BIT     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic in_bit,
  output logic out_bit,
  output logic rise,
  output logic fall,
  output logic busy
`ifdef DEBOUNCER_GLITCH_FLAG_EN
  ,
  input  logic glitch_clr,
  output logic glitch_flag
`endif
);

  localparam int            CW       = deb_cnt_w(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  deb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          busy_q, busy_d;
`ifdef DEBOUNCER_GLITCH_FLAG_EN
  logic          abort;
  logic          glitch_q, glitch_d;
`endif

  // Next-state logic: a sample equal to the current level always aborts, even on the accept edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
`ifdef DEBOUNCER_GLITCH_FLAG_EN
    abort   = 1'b0;
`endif
    case (state_q)
      ST_STABLE: begin
        if (in_bit != out_q) begin
          state_d = ST_COUNT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_COUNT: begin
        if (in_bit == out_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
`ifdef DEBOUNCER_GLITCH_FLAG_EN
          abort   = 1'b1;
`endif
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
          out_d   = in_bit;
          rise_d  = in_bit;
          fall_d  = ~in_bit;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == ST_COUNT);
`ifdef DEBOUNCER_GLITCH_FLAG_EN
    // Set beats clear when both happen on the same edge.
    glitch_d = abort ? 1'b1 : (glitch_clr ? 1'b0 : glitch_q);
`endif
  end

  // State and registered outputs; reset discards any count in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_STABLE;
      cnt_q    <= '0;
      out_q    <= RESET_BIT;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef DEBOUNCER_GLITCH_FLAG_EN
      glitch_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      busy_q   <= busy_d;
`ifdef DEBOUNCER_GLITCH_FLAG_EN
      glitch_q <= glitch_d;
`endif
    end
  end

  assign out_bit = out_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign busy    = busy_q;
`ifdef DEBOUNCER_GLITCH_FLAG_EN
  assign glitch_flag = glitch_q;
`endif

endmodule

// File: rtl/debouncer.sv
// N-bit debouncer with per-bit edge pulses; each bit is an independent debounce_cell.
// Define DEBOUNCER_GLITCH_FLAG_EN to add glitch_clr/glitch_flag ports.
module debouncer
  import debouncer_pkg::*;
#(
  parameter int           N             = 4,
  parameter int           STABLE_CYCLES = DEB_STABLE_CYCLES_DEF,
  parameter logic [N-1:0] RESET_VAL     = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in_d,
  output logic [N-1:0] out_q,
  output logic [N-1:0] rise_p,
  output logic [N-1:0] fall_p,
  output logic [N-1:0] busy
`ifdef DEBOUNCER_GLITCH_FLAG_EN
  ,
  input  logic [N-1:0] glitch_clr,
  output logic [N-1:0] glitch_flag
`endif
);

  // A one-sample window would make the FSM degenerate; refuse to elaborate.
  generate
    if (STABLE_CYCLES < 2) begin : g_bad_cycles
      $error("debouncer: STABLE_CYCLES must be >= 2");
    end
  endgenerate

  // One independent cell per bit.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cell
      debounce_cell #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .RESET_BIT     (RESET_VAL[gi])
      ) u_cell (
        .clk         (clk),
        .reset       (reset),
        .in_bit      (in_d[gi]),
        .out_bit     (out_q[gi]),
        .rise        (rise_p[gi]),
        .fall        (fall_p[gi]),
        .busy        (busy[gi])
`ifdef DEBOUNCER_GLITCH_FLAG_EN
        ,
        .glitch_clr  (glitch_clr[gi]),
        .glitch_flag (glitch_flag[gi])
`endif
      );
    end
  endgenerate

endmodule

// File: tb/tb_debouncer.sv
// Directed testbench for debouncer (N=4, STABLE_CYCLES=4, RESET_VAL=0).
// Glitch-flag scenarios compile in when DEBOUNCER_GLITCH_FLAG_EN is defined.
module tb_debouncer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_d;
  logic [3:0] out_q, rise_p, fall_p, busy;
`ifdef DEBOUNCER_GLITCH_FLAG_EN
  logic [3:0] glitch_clr;
  logic [3:0] glitch_flag;
`endif

  int checks   = 0;
  int failures = 0;

  always #50 clk = ~clk;

  debouncer #(.N(4), .STABLE_CYCLES(4), .RESET_VAL(4'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_d        (in_d),
    .out_q       (out_q),
    .rise_p      (rise_p),
    .fall_p      (fall_p),
    .busy        (busy)
`ifdef DEBOUNCER_GLITCH_FLAG_EN
    ,
    .glitch_clr  (glitch_clr),
    .glitch_flag (glitch_flag)
`endif
  );

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_d  = 4'hF;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (out_q !== 4'h0 || rise_p !== 4'h0 || fall_p !== 4'h0 || busy !== 4'h0) begin
      failures++;
      $display("FAIL reset_state: out=%h rise=%h fall=%h busy=%h required all 0", out_q, rise_p, fall_p, busy);
    end
    $display("reset: out=%h busy=%h", out_q, busy);
    reset = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      checks++;
      if (e < 4) begin
        if (out_q !== 4'h0 || busy !== 4'hF || rise_p !== 4'h0) begin
          failures++;
          $display("FAIL first_qual_e%0d: out=%h busy=%h rise=%h required out=0 busy=f rise=0", e, out_q, busy, rise_p);
        end
      end else begin
        if (out_q !== 4'hF || rise_p !== 4'hF || busy !== 4'h0 || fall_p !== 4'h0) begin
          failures++;
          $display("FAIL first_accept: out=%h rise=%h fall=%h busy=%h required out=f rise=f fall=0 busy=0", out_q, rise_p, fall_p, busy);
        end
      end
    end
    step();
    checks++;
    if (rise_p !== 4'h0 || out_q !== 4'hF) begin
      failures++;
      $display("FAIL rise_one_cycle: rise=%h out=%h required rise=0 out=f", rise_p, out_q);
    end
    $display("first accept: out=%h", out_q);
  endtask

  task automatic test_glitch();
    logic [3:0] rise_seen;
    in_d = 4'h0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (out_q !== 4'h0 || fall_p !== 4'hF || rise_p !== 4'h0) begin
      failures++;
      $display("FAIL fall_all: out=%h fall=%h rise=%h required out=0 fall=f rise=0", out_q, fall_p, rise_p);
    end
    step();
    rise_seen = 4'h0;
    in_d = 4'h1;
    for (int i = 0; i < 3; i++) begin
      step();
      rise_seen |= rise_p;
      checks++;
      if (busy !== 4'h1 || out_q !== 4'h0) begin
        failures++;
        $display("FAIL glitch_busy_c%0d: busy=%h out=%h required busy=1 out=0", i, busy, out_q);
      end
    end
    in_d = 4'h0;
    step();
    rise_seen |= rise_p;
    checks++;
    if (busy !== 4'h0 || out_q !== 4'h0 || rise_seen !== 4'h0) begin
      failures++;
      $display("FAIL glitch_abort: busy=%h out=%h rise_seen=%h required 0 0 0", busy, out_q, rise_seen);
    end
`ifdef DEBOUNCER_GLITCH_FLAG_EN
    checks++;
    if (glitch_flag[0] !== 1'b1) begin
      failures++;
      $display("FAIL glitch_flag0: flag=%b required 1", glitch_flag[0]);
    end
`endif
    $display("glitch on bit0: out=%h busy=%h", out_q, busy);
  endtask

  task automatic test_multi();
    in_d = 4'b0101;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (out_q !== 4'b0101 || rise_p !== 4'b0101) begin
      failures++;
      $display("FAIL multi_0101: out=%h rise=%h required 5 5", out_q, rise_p);
    end
    step();
    in_d = 4'b1010;
    for (int e = 1; e <= 4; e++) begin
      step();
      checks++;
      if (e < 4) begin
        if (out_q !== 4'b0101 || rise_p !== 4'h0 || fall_p !== 4'h0 || busy !== 4'hF) begin
          failures++;
          $display("FAIL multi_wait_e%0d: out=%h rise=%h fall=%h busy=%h required 5 0 0 f", e, out_q, rise_p, fall_p, busy);
        end
      end else begin
        if (out_q !== 4'b1010 || rise_p !== 4'b1010 || fall_p !== 4'b0101) begin
          failures++;
          $display("FAIL multi_accept: out=%h rise=%h fall=%h required a a 5", out_q, rise_p, fall_p);
        end
      end
    end
    $display("multi-bit swap: out=%h", out_q);
    step();
  endtask

  task automatic test_toggle();
    logic t;
    t = 1'b0;
    for (int i = 0; i < 20; i++) begin
      t = ~t;
      in_d = 4'b1010 | {1'b0, t, 2'b00};
      step();
      checks++;
      if (out_q !== 4'b1010 || rise_p[2] !== 1'b0 || fall_p[2] !== 1'b0) begin
        failures++;
        $display("FAIL toggle_c%0d: out=%h rise2=%b fall2=%b required out=a 0 0", i, out_q, rise_p[2], fall_p[2]);
      end
    end
    in_d = 4'b1010;
    step();
    $display("toggle bit2 x20: out=%h", out_q);
  endtask

  task automatic test_reset_mid();
    in_d = 4'h0;
    for (int i = 0; i < 4; i++) step();
    step();
    checks++;
    if (out_q !== 4'h0) begin
      failures++;
      $display("FAIL mid_setup: out=%h required 0", out_q);
    end
    in_d = 4'b0010;
    step();
    step();
    checks++;
    if (busy !== 4'b0010) begin
      failures++;
      $display("FAIL mid_busy: busy=%h required 2", busy);
    end
    #20;
    reset = 1'b1;
    #1;
    checks++;
    if (out_q !== 4'h0 || busy !== 4'h0 || rise_p !== 4'h0) begin
      failures++;
      $display("FAIL mid_async: out=%h busy=%h rise=%h required 0 0 0", out_q, busy, rise_p);
    end
    step();
    reset = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      checks++;
      if (e < 4) begin
        if (out_q !== 4'h0 || busy !== 4'b0010 || rise_p !== 4'h0) begin
          failures++;
          $display("FAIL mid_requal_e%0d: out=%h busy=%h rise=%h required 0 2 0", e, out_q, busy, rise_p);
        end
      end else begin
        if (out_q !== 4'b0010 || rise_p !== 4'b0010) begin
          failures++;
          $display("FAIL mid_accept: out=%h rise=%h required 2 2", out_q, rise_p);
        end
      end
    end
    $display("reset mid-count: out=%h", out_q);
  endtask

`ifdef DEBOUNCER_GLITCH_FLAG_EN
  task automatic test_glitch_clr();
    step();
    glitch_clr = 4'hF;
    step();
    glitch_clr = 4'h0;
    checks++;
    if (glitch_flag !== 4'h0) begin
      failures++;
      $display("FAIL gflag_clear_all: flag=%h required 0", glitch_flag);
    end
    in_d = 4'b1010;
    step();
    in_d = 4'b0010;
    step();
    checks++;
    if (glitch_flag[3] !== 1'b1) begin
      failures++;
      $display("FAIL gflag_set3: flag3=%b required 1", glitch_flag[3]);
    end
    in_d = 4'b1010;
    step();
    in_d = 4'b0010;
    glitch_clr = 4'b1000;
    step();
    glitch_clr = 4'h0;
    checks++;
    if (glitch_flag[3] !== 1'b1) begin
      failures++;
      $display("FAIL gflag_set_wins: flag3=%b required 1", glitch_flag[3]);
    end
    glitch_clr = 4'b1000;
    step();
    glitch_clr = 4'h0;
    checks++;
    if (glitch_flag[3] !== 1'b0) begin
      failures++;
      $display("FAIL gflag_clear3: flag3=%b required 0", glitch_flag[3]);
    end
    $display("glitch flag clr: flag=%h", glitch_flag);
  endtask
`endif

  initial begin
`ifdef DEBOUNCER_GLITCH_FLAG_EN
    glitch_clr = 4'h0;
`endif
    test_reset();
    test_glitch();
    test_multi();
    test_toggle();
    test_reset_mid();
`ifdef DEBOUNCER_GLITCH_FLAG_EN
    test_glitch_clr();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
